// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int ADDR_W_DEF = 4;
    // Entries store dest at a fixed maximum width so the struct is shared across ADDR_W builds.
    localparam int ADDR_W_MAX = 8;
    localparam int FWD_NONE   = 0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_MAX-1:0] dest;
        logic                  is_load;
    } sb_entry_t;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle: decoded operand info in, stall/forward info out.
interface hazard_scoreboard_if #(
    parameter int ADDR_W  = hazard_scoreboard_pkg::ADDR_W_DEF,
    parameter int NUM_SRC = 3,
    parameter int STAGES  = 2,
    parameter int CNT_W   = 16
);
    import hazard_scoreboard_pkg::*;

    localparam int SEL_W = sel_width(STAGES);

    logic                      fwd_en;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic                      id_wb_en;
    logic [ADDR_W-1:0]         id_dest;
    logic                      id_mem_read;
    logic                      flush;
    logic                      hazard;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic [(1<<ADDR_W)-1:0]    pending;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output fwd_en, id_valid, src_addr, src_used, id_wb_en, id_dest, id_mem_read, flush,
        input  hazard, fwd_sel, pending, stall_count
    );

    modport slave (
        input  fwd_en, id_valid, src_addr, src_used, id_wb_en, id_dest, id_mem_read, flush,
        output hazard, fwd_sel, pending, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_src_match.sv
// One source operand against every in-flight entry: any match, load-use on EXE, youngest forward select.
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int SEL_W  = sel_width(STAGES)
) (
    input  logic                  active,
    input  logic [ADDR_W_MAX-1:0] addr,
    input  sb_entry_t [STAGES-1:0] entries,
    output logic                  any_match,
    output logic                  load_use,
    output logic [SEL_W-1:0]      sel
);

    always_comb begin
        any_match = 1'b0;
        sel       = SEL_W'(FWD_NONE);
        // Walk oldest to youngest so the youngest match overwrites sel last.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (active && entries[k].valid && (entries[k].dest == addr)) begin
                any_match = 1'b1;
                sel       = SEL_W'(k + 1);
            end
        end
        load_use = active && entries[0].valid && entries[0].is_load && (entries[0].dest == addr);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes between ID and WB; drives stall and forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_SRC = 3,
    parameter int STAGES  = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);

    localparam int SEL_W = sel_width(STAGES);

    sb_entry_t [STAGES-1:0]          sb_q, sb_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_SRC-1:0]              any_match, load_use;
    logic [NUM_SRC-1:0][SEL_W-1:0]   src_sel;
    logic [NUM_SRC*SEL_W-1:0]        fwd_sel;
    logic [(1<<ADDR_W)-1:0]          pending;
    logic                            hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_match (
            .active    (bus.id_valid & bus.src_used[i]),
            .addr      (ADDR_W_MAX'(bus.src_addr[i*ADDR_W +: ADDR_W])),
            .entries   (sb_q),
            .any_match (any_match[i]),
            .load_use  (load_use[i]),
            .sel       (src_sel[i])
        );
    end

    // With forwarding only a load still in EXE cannot be bypassed in time.
    assign hazard = bus.fwd_en ? |load_use : |any_match;

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++)
            fwd_sel[i*SEL_W +: SEL_W] = bus.fwd_en ? src_sel[i] : SEL_W'(FWD_NONE);

        pending = '0;
        for (int k = 0; k < STAGES; k++)
            if (sb_q[k].valid) pending[sb_q[k].dest[ADDR_W-1:0]] = 1'b1;

        sb_d[0].valid   = bus.id_valid & bus.id_wb_en & ~hazard & ~bus.flush;
        sb_d[0].dest    = ADDR_W_MAX'(bus.id_dest);
        sb_d[0].is_load = bus.id_mem_read;
        for (int k = 1; k < STAGES; k++)
            sb_d[k] = sb_q[k-1];

        cnt_d = cnt_q;
        if (hazard && !bus.flush && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.hazard      = hazard;
    assign bus.fwd_sel     = fwd_sel;
    assign bus.pending     = pending;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + random checks of hazard_scoreboard against an in-flight-list reference model.
module tb_hazard_scoreboard;

    localparam int ADDR_W  = 4;
    localparam int NUM_SRC = 3;
    localparam int STAGES  = 2;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .STAGES(STAGES), .CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: list of instructions issued past ID, index 0 = youngest.
    typedef struct { bit v; int dest; bit ld; } inf_t;
    inf_t fl_q[$];
    int   m_cnt;

    bit   s_rst, s_fwd, s_valid, s_wb, s_mr, s_flush;
    bit [NUM_SRC-1:0] s_used;
    int   s_src[NUM_SRC];
    int   s_dest;

    bit   e_hz;
    int   e_sel[NUM_SRC];
    logic [(1<<ADDR_W)-1:0] e_pend;

    logic o_hz;
    int   o_sel[NUM_SRC];
    logic [(1<<ADDR_W)-1:0] o_pend;
    int   o_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input bit wb, input int dest, input bit mr,
                          input bit [NUM_SRC-1:0] used, input int a0, input int a1, input int a2,
                          input bit fl);
        s_valid = v; s_wb = wb; s_dest = dest; s_mr = mr; s_used = used;
        s_src[0] = a0; s_src[1] = a1; s_src[2] = a2; s_flush = fl;
    endtask

    task automatic apply();
        logic [ADDR_W-1:0] a;
        rst             = s_rst;
        bus.fwd_en      = s_fwd;
        bus.id_valid    = s_valid;
        bus.src_used    = s_used;
        bus.id_wb_en    = s_wb;
        bus.id_dest     = ADDR_W'(s_dest);
        bus.id_mem_read = s_mr;
        bus.flush       = s_flush;
        for (int i = 0; i < NUM_SRC; i++) begin
            a = ADDR_W'(s_src[i]);
            bus.src_addr[i*ADDR_W +: ADDR_W] = a;
        end
    endtask

    task automatic model_eval();
        int young;
        e_hz   = 1'b0;
        e_pend = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            young = 0;
            for (int k = 0; k < fl_q.size(); k++) begin
                if (s_valid && s_used[i] && fl_q[k].v && fl_q[k].dest == s_src[i]) begin
                    if (young == 0) young = k + 1;
                    if (!s_fwd || (k == 0 && fl_q[k].ld)) e_hz = 1'b1;
                end
            end
            e_sel[i] = s_fwd ? young : 0;
        end
        for (int k = 0; k < fl_q.size(); k++)
            if (fl_q[k].v) e_pend[fl_q[k].dest] = 1'b1;
    endtask

    task automatic model_update();
        inf_t e;
        if (s_rst) begin
            fl_q.delete();
            e.v = 1'b0; e.dest = 0; e.ld = 1'b0;
            for (int k = 0; k < STAGES; k++) fl_q.push_back(e);
            m_cnt = 0;
        end else begin
            if (e_hz && !s_flush && m_cnt < CNT_MAX) m_cnt++;
            e.v    = s_valid && s_wb && !e_hz && !s_flush;
            e.dest = s_dest;
            e.ld   = s_mr;
            fl_q.push_front(e);
            void'(fl_q.pop_back());
        end
    endtask

    // One cycle: drive, sample at negedge, check against model, advance model at posedge.
    task automatic step(input string tag, input bit do_chk = 1'b1);
        apply();
        @(negedge clk);
        o_hz   = bus.hazard;
        o_pend = bus.pending;
        o_cnt  = int'(bus.stall_count);
        for (int i = 0; i < NUM_SRC; i++) o_sel[i] = int'(bus.fwd_sel[i*SEL_W +: SEL_W]);
        model_eval();
        if (do_chk) begin
            chk({tag, "_hazard"}, o_hz, e_hz);
            for (int i = 0; i < NUM_SRC; i++) chk({tag, "_fwd_sel"}, o_sel[i], e_sel[i]);
            chk({tag, "_pending"}, o_pend, e_pend);
            chk({tag, "_count"}, o_cnt, m_cnt);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        set_id(0, 0, 0, 0, '0, 0, 0, 0, 0);
        step("rst", 1'b0);
        s_rst = 1'b0;
    endtask

    initial begin
        s_fwd = 1'b0;

        // Reset state
        do_reset();
        step("idle");
        chk("rst_hazard", o_hz, 0);
        chk("rst_pending", o_pend, 0);
        chk("rst_count", o_cnt, 0);

        // T1: stall-only mode, ADD R3 then reader of R3
        do_reset();
        s_fwd = 1'b0;
        set_id(1, 1, 3, 0, 3'b000, 0, 0, 0, 0); step("t1_add");
        set_id(1, 0, 0, 0, 3'b001, 3, 0, 0, 0); step("t1_c1");
        chk("t1_hz_c1", o_hz, 1);
        step("t1_c2"); chk("t1_hz_c2", o_hz, 1);
        step("t1_c3"); chk("t1_hz_c3", o_hz, 0);
        chk("t1_count", o_cnt, 2);

        // T2: forwarding, ADD R3 then two readers
        do_reset();
        s_fwd = 1'b1;
        set_id(1, 1, 3, 0, 3'b000, 0, 0, 0, 0); step("t2_add");
        set_id(1, 0, 0, 0, 3'b001, 3, 0, 0, 0); step("t2_sub");
        chk("t2_hz", o_hz, 0);
        chk("t2_sel1", o_sel[0], 1);
        step("t2_nxt");
        chk("t2_sel2", o_sel[0], 2);

        // T3: load-use on src1
        do_reset();
        s_fwd = 1'b1;
        set_id(1, 1, 5, 1, 3'b000, 0, 0, 0, 0); step("t3_ldr");
        set_id(1, 0, 0, 0, 3'b010, 0, 5, 0, 0); step("t3_use");
        chk("t3_hz_c1", o_hz, 1);
        step("t3_fwd");
        chk("t3_hz_c2", o_hz, 0);
        chk("t3_sel", o_sel[1], 2);

        // T4: double write to R2, youngest wins, pending lingers
        do_reset();
        s_fwd = 1'b1;
        set_id(1, 1, 2, 0, 3'b000, 0, 0, 0, 0); step("t4_add1");
        step("t4_add2");
        chk("t4_pend_a", o_pend[2], 1);
        set_id(1, 0, 0, 0, 3'b001, 2, 0, 0, 0); step("t4_rd");
        chk("t4_sel_young", o_sel[0], 1);
        chk("t4_pend_b", o_pend[2], 1);
        set_id(0, 0, 0, 0, 3'b000, 0, 0, 0, 0); step("t4_bub");
        chk("t4_pend_c", o_pend[2], 1);
        step("t4_gone");
        chk("t4_pend_d", o_pend, 0);

        // T5a: hazard and flush together
        do_reset();
        s_fwd = 1'b0;
        set_id(1, 1, 4, 0, 3'b000, 0, 0, 0, 0); step("t5_add");
        set_id(1, 1, 9, 0, 3'b001, 4, 0, 0, 1); step("t5_flush");
        chk("t5_hz_flush", o_hz, 1);
        set_id(0, 0, 0, 0, 3'b000, 0, 0, 0, 0); step("t5_after");
        chk("t5_count", o_cnt, 0);
        chk("t5_pend", o_pend, 16'h0010);

        // T5b: reset during a stall
        set_id(1, 1, 6, 0, 3'b000, 0, 0, 0, 0); step("t5_add6");
        set_id(1, 0, 0, 0, 3'b001, 6, 0, 0, 0); step("t5_stall");
        chk("t5_hz_stall", o_hz, 1);
        s_rst = 1'b1; step("t5_rst");
        s_rst = 1'b0; step("t5_post");
        chk("t5_hz_post", o_hz, 0);
        chk("t5_pend_post", o_pend, 0);

        // T6: continuous load-use loop saturates the counter
        do_reset();
        s_fwd = 1'b1;
        set_id(1, 1, 7, 1, 3'b001, 7, 0, 0, 0);
        for (int n = 0; n < 40; n++) step("t6_loop");
        chk("t6_sat", o_cnt, CNT_MAX);
        set_id(1, 1, 7, 1, 3'b000, 7, 7, 7, 0); step("t6_unused");
        chk("t6_unused_hz", o_hz, 0);

        // Random traffic on a small register window to provoke matches
        do_reset();
        for (int n = 0; n < 400; n++) begin
            s_rst = ($urandom_range(0, 39) == 0);
            s_fwd = $urandom_range(0, 1);
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), NUM_SRC'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 9) == 0);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
